// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame deserializer.
//   state_e   : receiver FSM states (IDLE, DATA, STOP)
//   START_LVL : line level of the start bit
//   STOP_LVL  : line level of a valid stop bit
//   IDLE_LVL  : line level while no frame is in flight
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } state_e;

  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit serial-in / parallel-out shift register.
// Bits enter at the MSB and move toward bit 0, so after WIDTH shifts the
// first bit received sits in data_o[0] (LSB-first assembly).
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset, clears the register
//   clr_i      : synchronous clear (wins over shift_en_i)
//   shift_en_i : shift bit_i in on this edge
//   bit_i      : serial input bit
//   data_o     : parallel register contents
module sipo_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             shift_en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (shift_en_i) begin
      data_q <= {bit_i, data_q[WIDTH-1:1]};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/serial_frame_deser.sv
// Serial frame deserializer: start bit (1), WIDTH payload bits LSB-first,
// stop bit (0). Good frames are presented on a valid/ready output slot.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   din        : registered serial bit, one per clock
//   dout       : assembled payload, bit 0 = first payload bit
//   dout_valid : dout holds an unconsumed word
//   dout_ready : consumer accepts dout when dout_valid && dout_ready
//   frame_err  : one-cycle pulse, stop bit sampled as 1
//   overrun    : one-cycle pulse, good frame dropped because slot was held
module serial_frame_deser
  import serial_frame_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic             sr_clr, sr_shift;
  logic [WIDTH-1:0] payload;
  logic             good_frame, bad_frame;
  logic             slot_free;

  sipo_shift_reg #(
    .WIDTH(WIDTH)
  ) u_sipo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (sr_clr),
    .shift_en_i(sr_shift),
    .bit_i     (din),
    .data_o    (payload)
  );

  // Receiver FSM and bit counter.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sr_clr     = 1'b0;
    sr_shift   = 1'b0;
    good_frame = 1'b0;
    bad_frame  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (din == START_LVL) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          sr_clr    = 1'b1;
        end
      end
      DATA: begin
        sr_shift = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      STOP: begin
        state_d = IDLE;
        if (din == STOP_LVL) begin
          good_frame = 1'b1;
        end else begin
          bad_frame = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output slot: a word consumed on this edge frees the slot for a
  // simultaneous load, so valid stays high across back-to-back words.
  always_comb begin
    slot_free    = !dout_valid_q || dout_ready;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q && !dout_ready;
    frame_err_d  = bad_frame;
    overrun_d    = 1'b0;
    if (good_frame) begin
      if (slot_free) begin
        dout_d       = payload;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
